mem_bus_arbiter: RTL

//  Shares the single 128-bit memory bus between the instruction-cache refill port (I) and the

---
 rtl/mem_bus_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one 128-bit memory bus between the I-cache refill port and the D-cache/LSU port.
// One outstanding transaction; the grant is held until the memory responds.
module mem_bus_arbiter #(
  parameter int unsigned BUS_ADDRESS_WIDTH = 20,
  parameter int unsigned BUS_DATA_WIDTH    = 128
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [BUS_ADDRESS_WIDTH-1:4]    i_addr_i,
  input  logic                            i_valid_i,
  output logic                            i_valid_o,
  input  logic [BUS_ADDRESS_WIDTH-1:4]    d_addr_i,
  input  logic                            d_we_i,
  input  logic [BUS_DATA_WIDTH-1:0]       d_wdata_i,
  input  logic                            d_valid_i,
  output logic                            d_valid_o,
  output logic [BUS_DATA_WIDTH-1:0]       rdata_o,
  output logic [BUS_ADDRESS_WIDTH-1:4]    mem_addr_o,
  output logic                            mem_we_o,
  output logic [BUS_DATA_WIDTH-1:0]       mem_wdata_o,
  output logic                            mem_valid_o,
  input  logic [BUS_DATA_WIDTH-1:0]       mem_rdata_i,
  input  logic                            mem_valid_i,
  output logic                            spurious_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_d_q;
  logic   mask_i_q, mask_d_q;
  logic   grant_i, grant_d;
  logic   elig_i, elig_d;

  assign rdata_o = mem_rdata_i;
  assign elig_i  = i_valid_i & ~mask_i_q;
  assign elig_d  = d_valid_i & ~mask_d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    i_valid_o = 1'b0;
    d_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        grant_i = elig_i & (~elig_d | last_grant_d_q);
        grant_d = elig_d & ~grant_i;
        if (grant_i) begin
          state_d = BUSY_I;
        end else if (grant_d) begin
          state_d = BUSY_D;
        end
      end
      BUSY_I: begin
        if (mem_valid_i) begin
          i_valid_o = 1'b1;
          state_d   = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_valid_i) begin
          d_valid_o = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_addr_o     <= '0;
      mem_we_o       <= 1'b0;
      mem_wdata_o    <= '0;
      mem_valid_o    <= 1'b0;
      last_grant_d_q <= 1'b1;
      mask_i_q       <= 1'b0;
      mask_d_q       <= 1'b0;
      spurious_o     <= 1'b0;
    end else begin
      // Masks live for exactly the one IDLE cycle after a port's response.
      mask_i_q <= i_valid_o;
      mask_d_q <= d_valid_o;
      if (grant_i) begin
        mem_addr_o     <= i_addr_i;
        mem_we_o       <= 1'b0;
        mem_wdata_o    <= '0;
        mem_valid_o    <= 1'b1;
        last_grant_d_q <= 1'b0;
      end else if (grant_d) begin
        mem_addr_o     <= d_addr_i;
        mem_we_o       <= d_we_i;
        mem_wdata_o    <= d_wdata_i;
        mem_valid_o    <= 1'b1;
        last_grant_d_q <= 1'b1;
      end else if (i_valid_o || d_valid_o) begin
        mem_valid_o <= 1'b0;
      end
      if (state_q == IDLE && mem_valid_i) begin
        spurious_o <= 1'b1;
      end
    end
  end

endmodule
